depacketizer: RTL and testbench
===============================

DEPACKETIZER -- requirements
Module: depacketizer

Interface
REQ-001 SHALL have parameter local_mac, default 48'h02_12_34_56_67_90, the station MAC accepted as destination.
REQ-002 SHALL have parameter local_ip, default {8'd10,8'd0,8'd0,8'd2}, the accepted destination IPv4 address.
REQ-003 SHALL have parameter local_port, default 16'd32179, the accepted destination UDP port.
REQ-004 SHALL have port clk, input, 1, the single clock; reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ff_rx_clk, output, 1, driven directly by clk to the MAC receive FIFO.
REQ-006 SHALL have ports ff_rx_data input 32, ff_rx_sop input 1, ff_rx_eop input 1, ff_rx_mod input 2, ff_rx_dval input 1, rx_err input 6, and ff_rx_rdy output 1, forming the MAC receive stream.
REQ-007 SHALL have ports wr_data output 32, wr_en output 1, wr_full input 1, forming the payload sink.
REQ-008 SHALL have ports pkt_done output 1, pkt_drop output 1, drop_count output 16.

Function
REQ-009 A beat SHALL be accepted when ff_rx_dval and ff_rx_rdy are both 1.
REQ-010 ff_rx_rdy SHALL be combinational: 0 only in PAYLOAD with wr_full=1, otherwise 1.
REQ-011 Frames SHALL arrive with 2 leading pad bytes (MAC shift16), big-endian, first byte in [31:24], giving an 11-word header with word 11 onward as payload.
REQ-012 The header SHALL be checked per word: w0[15:0]/w1 = local_mac; w3[15:0] = 16'h0800; w4[31:24] = 8'h45; w6[23:16] = 8'd17; w8 = local_ip; w9[15:0] = local_port; w10[31:16] (udp_len) >= 8.
REQ-013 The FSM SHALL have states IDLE, HEADER, PAYLOAD, TAIL, DROP.
- IDLE: accepted sop goes to HEADER with word index 1; non-sop beats are ignored.
- HEADER: any check failure goes to DROP; after word 10 passes, go to PAYLOAD, or to TAIL if (udp_len-8)/4 = 0.
- PAYLOAD: each accepted beat is written out and the remaining count decrements; count reaching 0 goes to TAIL.
- TAIL/DROP: beats are consumed until eop.
REQ-014 Payload word count SHALL be floor((udp_len-8)/4); trailing partial bytes and Ethernet padding SHALL be discarded.
REQ-015 wr_data/wr_en SHALL be registered, asserting 1 cycle after the accepted payload beat.
REQ-016 At eop, the cycle after, exactly one of pkt_done or pkt_drop SHALL pulse for 1 cycle, then the FSM SHALL return to IDLE.
- pkt_done: eop in TAIL with rx_err = 0, or in PAYLOAD on the last counted word.
- pkt_drop: all other cases.
REQ-017 eop in HEADER, eop in PAYLOAD before the count is exhausted (runt), or nonzero rx_err at eop SHALL give pkt_drop; payload words already written are not retracted.
REQ-018 sop accepted in any state other than IDLE SHALL pulse pkt_drop for the aborted frame and restart HEADER at word index 1.
REQ-019 drop_count SHALL increment on every pkt_drop and saturate at 16'hFFFF.
REQ-020 ff_rx_mod SHALL be ignored except that it does not affect length.

Reset
REQ-021 reset_n low SHALL asynchronously force IDLE, wr_en=0, wr_data=0, pkt_done=0, pkt_drop=0, drop_count=0, and the counters to 0.
REQ-022 Reset mid-frame SHALL discard the frame without a pulse, and the post-reset state SHALL ignore beats until the next sop.

Verification
REQ-023 Valid frame with udp_len=24 (4 payload words 1,2,3,4), rx_err=0 -> wr_en high 4 cycles with data 1..4 in order, then a single pkt_done, drop_count=0.
REQ-024 Same frame with dst_port=1234 -> no wr_en, pkt_drop pulses once after eop, drop_count=1.
REQ-025 Valid frame with wr_full held 5 cycles during payload -> ff_rx_rdy=0 for those cycles, no word lost or duplicated, pkt_done.
REQ-026 Valid frame with udp_len=8 plus 4 pad words -> no wr_en, pkt_done; same frame with rx_err=6'h01 at eop -> pkt_drop.
REQ-027 New sop at header word 5, then a full valid frame -> pkt_drop once, then full payload written and pkt_done.
REQ-028 reset_n pulsed low during payload word 2 -> outputs at reset values immediately, no pulse, next valid frame processed normally.

Source files
------------

// File: rtl/depacketizer.sv
// UDP/IPv4 depacketizer: filters frames from a shift16 MAC receive FIFO by
// destination MAC/IP/port and forwards the counted UDP payload words.
module depacketizer #(
    parameter logic [47:0] local_mac  = 48'h02_12_34_56_67_90,
    parameter logic [31:0] local_ip   = {8'd10, 8'd0, 8'd0, 8'd2},
    parameter logic [15:0] local_port = 16'd32179
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ff_rx_clk,
    input  logic [31:0] ff_rx_data,
    input  logic        ff_rx_sop,
    input  logic        ff_rx_eop,
    input  logic [1:0]  ff_rx_mod,
    input  logic        ff_rx_dval,
    input  logic [5:0]  rx_err,
    output logic        ff_rx_rdy,
    output logic [31:0] wr_data,
    output logic        wr_en,
    input  logic        wr_full,
    output logic        pkt_done,
    output logic        pkt_drop,
    output logic [15:0] drop_count
);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TAIL, DROP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [13:0] cnt_q, cnt_d;
    logic        mac_hi_ok_q, mac_hi_ok_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        pkt_done_q, pkt_done_d;
    logic        pkt_drop_q, pkt_drop_d;
    logic [15:0] drop_count_q, drop_count_d;

    logic        accept;
    logic        hdr_ok;
    logic [15:0] pay_bytes;
    logic        unused_mod;

    assign ff_rx_clk  = clk;
    assign ff_rx_rdy  = !((state_q == PAYLOAD) && wr_full);
    assign accept     = ff_rx_dval && ff_rx_rdy;
    assign pay_bytes  = ff_rx_data[31:16] - 16'd8;
    assign unused_mod = ^ff_rx_mod;

    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_drop   = pkt_drop_q;
    assign drop_count = drop_count_q;

    // The upper MAC half sits in the sop beat; it is latched and judged with word 1.
    always_comb begin
        hdr_ok = 1'b1;
        case (idx_q)
            4'd1:    hdr_ok = mac_hi_ok_q && (ff_rx_data == local_mac[31:0]);
            4'd3:    hdr_ok = ff_rx_data[15:0] == 16'h0800;
            4'd4:    hdr_ok = ff_rx_data[31:24] == 8'h45;
            4'd6:    hdr_ok = ff_rx_data[23:16] == 8'd17;
            4'd8:    hdr_ok = ff_rx_data == local_ip;
            4'd9:    hdr_ok = ff_rx_data[15:0] == local_port;
            4'd10:   hdr_ok = ff_rx_data[31:16] >= 16'd8;
            default: hdr_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        mac_hi_ok_d = mac_hi_ok_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_drop_d  = 1'b0;

        if (accept) begin
            if (ff_rx_sop) begin
                pkt_drop_d  = (state_q != IDLE);
                mac_hi_ok_d = ff_rx_data[15:0] == local_mac[47:32];
                idx_d       = 4'd1;
                if (ff_rx_eop) begin
                    pkt_drop_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = HEADER;
                end
            end else begin
                case (state_q)
                    HEADER: begin
                        if (ff_rx_eop) begin
                            pkt_drop_d = 1'b1;
                            state_d    = IDLE;
                        end else if (!hdr_ok) begin
                            state_d = DROP;
                        end else if (idx_q == 4'd10) begin
                            cnt_d   = pay_bytes[15:2];
                            state_d = (pay_bytes[15:2] == '0) ? TAIL : PAYLOAD;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                    PAYLOAD: begin
                        wr_en_d   = 1'b1;
                        wr_data_d = ff_rx_data;
                        cnt_d     = cnt_q - 14'd1;
                        if (ff_rx_eop) begin
                            state_d = IDLE;
                            if ((rx_err == '0) && (cnt_q == 14'd1)) pkt_done_d = 1'b1;
                            else                                    pkt_drop_d = 1'b1;
                        end else if (cnt_q == 14'd1) begin
                            state_d = TAIL;
                        end
                    end
                    TAIL: begin
                        if (ff_rx_eop) begin
                            state_d = IDLE;
                            if (rx_err == '0) pkt_done_d = 1'b1;
                            else              pkt_drop_d = 1'b1;
                        end
                    end
                    DROP: begin
                        if (ff_rx_eop) begin
                            state_d    = IDLE;
                            pkt_drop_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        drop_count_d = drop_count_q;
        if (pkt_drop_d && (drop_count_q != '1)) drop_count_d = drop_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            mac_hi_ok_q  <= 1'b0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_drop_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            mac_hi_ok_q  <= mac_hi_ok_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            pkt_done_q   <= pkt_done_d;
            pkt_drop_q   <= pkt_drop_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_depacketizer.sv
// Scoreboard bench for depacketizer: expectations come from a frame-level
// model of the filtering/length rules; a negedge monitor pops and compares.
module tb_depacketizer;

    localparam logic [47:0] MAC  = 48'h02_12_34_56_67_90;
    localparam logic [31:0] IP   = {8'd10, 8'd0, 8'd0, 8'd2};
    localparam logic [15:0] PORT = 16'd32179;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ff_rx_clk;
    logic [31:0] ff_rx_data;
    logic        ff_rx_sop, ff_rx_eop, ff_rx_dval;
    logic [1:0]  ff_rx_mod;
    logic [5:0]  rx_err;
    logic        ff_rx_rdy;
    logic [31:0] wr_data;
    logic        wr_en, wr_full;
    logic        pkt_done, pkt_drop;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    depacketizer #(.local_mac(MAC), .local_ip(IP), .local_port(PORT)) dut (
        .clk(clk), .reset_n(reset_n), .ff_rx_clk(ff_rx_clk),
        .ff_rx_data(ff_rx_data), .ff_rx_sop(ff_rx_sop), .ff_rx_eop(ff_rx_eop),
        .ff_rx_mod(ff_rx_mod), .ff_rx_dval(ff_rx_dval), .rx_err(rx_err),
        .ff_rx_rdy(ff_rx_rdy), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
        .pkt_done(pkt_done), .pkt_drop(pkt_drop), .drop_count(drop_count)
    );

    typedef struct packed {
        logic        is_drop;
        logic [15:0] cnt;
    } ev_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_wr[$];
    ev_t         exp_ev[$];
    logic [15:0] model_drops = '0;
    logic [31:0] frm[$];
    bit          gap_en = 0;
    bit          bp_en  = 0;
    ev_t         mon_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got %h expected no write", wr_data);
            end else begin
                check("wr_data", wr_data, exp_wr.pop_front());
            end
        end
        if (pkt_done === 1'b1 || pkt_drop === 1'b1) begin
            if (exp_ev.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got done=%b drop=%b expected none", pkt_done, pkt_drop);
            end else begin
                mon_ev = exp_ev.pop_front();
                check("done_drop", 32'({pkt_done, pkt_drop}), mon_ev.is_drop ? 32'd1 : 32'd2);
                check("drop_count", 32'(drop_count), 32'(mon_ev.cnt));
            end
        end
    end

    // Frame-level reference: header fields by byte position, payload = floor((udp_len-8)/4) words.
    task automatic push_expect(input bit has_eop, input logic [5:0] err);
        int unsigned n = frm.size();
        bit ok = 0;
        int unsigned cnt = 0;
        int unsigned nw;
        logic [15:0] ulen;
        if (n > 11) begin
            ulen = frm[10][31:16];
            ok = ({frm[0][15:0], frm[1]} == MAC) && (frm[3][15:0] == 16'h0800) &&
                 (frm[4][31:24] == 8'h45) && (frm[6][23:16] == 8'd17) &&
                 (frm[8] == IP) && (frm[9][15:0] == PORT) && (ulen >= 16'd8);
            if (ok) cnt = (int'(ulen) - 8) / 4;
        end
        if (ok) begin
            nw = (cnt < n - 11) ? cnt : n - 11;
            for (int unsigned i = 0; i < nw; i++) exp_wr.push_back(frm[11 + i]);
        end
        if (has_eop && ok && err == '0 && (n - 11) >= cnt) begin
            exp_ev.push_back({1'b0, model_drops});
        end else begin
            if (model_drops != 16'hFFFF) model_drops = model_drops + 16'd1;
            exp_ev.push_back({1'b1, model_drops});
        end
    endtask

    task automatic make_frame(input logic [15:0] ulen, input logic [15:0] port,
                              input int unsigned npay, input logic [31:0] base);
        frm.delete();
        frm.push_back({16'h0000, MAC[47:32]});
        frm.push_back(MAC[31:0]);
        frm.push_back(32'h0011_2233);
        frm.push_back({16'h4455, 16'h0800});
        frm.push_back({8'h45, 8'h00, ulen + 16'd20});
        frm.push_back(32'h1234_4000);
        frm.push_back({8'h40, 8'd17, 16'h0000});
        frm.push_back({8'd10, 8'd0, 8'd0, 8'd1});
        frm.push_back(IP);
        frm.push_back({16'd5000, port});
        frm.push_back({ulen, 16'h0000});
        for (int unsigned i = 0; i < npay; i++) frm.push_back(base + i);
    endtask

    task automatic idle(input int unsigned n);
        ff_rx_dval = 0; ff_rx_sop = 0; ff_rx_eop = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop, input logic [5:0] err);
        int unsigned guard = 0;
        bit done = 0;
        bit rdy_s;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            ff_rx_dval = 0; ff_rx_sop = 0; ff_rx_eop = 0; ff_rx_data = $urandom;
            @(posedge clk);
            #1;
        end
        ff_rx_data = d; ff_rx_sop = sop; ff_rx_eop = eop; rx_err = err;
        ff_rx_mod = 2'($urandom); ff_rx_dval = 1;
        while (!done) begin
            wr_full = bp_en ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(negedge clk);
            rdy_s = ff_rx_rdy;
            @(posedge clk);
            #1;
            if (rdy_s) done = 1;
            else if (++guard > 1000) begin
                $display("FAIL beat_accept_timeout: got no accept expected accept within 1000 cycles");
                $fatal(1, "stalled");
            end
        end
        ff_rx_dval = 0; ff_rx_sop = 0; ff_rx_eop = 0; rx_err = '0;
    endtask

    task automatic send_frame(input bit has_eop, input logic [5:0] err, input int stall_at);
        int unsigned last = frm.size() - 1;
        for (int unsigned i = 0; i <= last; i++) begin
            if (int'(i) == stall_at) begin
                for (int c = 0; c < 5; c++) begin
                    ff_rx_data = frm[i]; ff_rx_sop = 0; ff_rx_eop = 0; ff_rx_dval = 1;
                    wr_full = 1;
                    @(negedge clk);
                    check("rdy_during_full", 32'(ff_rx_rdy), 32'd0);
                    @(posedge clk);
                    #1;
                end
                wr_full = 0;
            end
            send_beat(frm[i], i == 0, has_eop && i == last, (has_eop && i == last) ? err : 6'h00);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int unsigned k;
        bit          he;
        logic [5:0]  e;

        reset_n = 0; ff_rx_data = '0; ff_rx_sop = 0; ff_rx_eop = 0; ff_rx_mod = '0;
        ff_rx_dval = 0; rx_err = '0; wr_full = 0;
        #12;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_pkt_drop", 32'(pkt_drop), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_rdy", 32'(ff_rx_rdy), 32'd1);
        @(negedge clk);
        reset_n = 1;
        check("rx_clk_low", 32'(ff_rx_clk), 32'd0);
        @(posedge clk);
        #1;
        check("rx_clk_high", 32'(ff_rx_clk), 32'd1);

        make_frame(16'd24, PORT, 4, 32'd1);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1); idle(3);

        make_frame(16'd24, 16'd1234, 4, 32'd1);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1); idle(3);

        make_frame(16'd24, PORT, 4, 32'd100);
        push_expect(1, 6'h00); send_frame(1, 6'h00, 12); idle(3);

        make_frame(16'd8, PORT, 4, 32'd200);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1); idle(3);
        push_expect(1, 6'h01); send_frame(1, 6'h01, -1); idle(3);

        make_frame(16'd24, PORT, 4, 32'd300);
        while (frm.size() > 5) void'(frm.pop_back());
        push_expect(0, 6'h00); send_frame(0, 6'h00, -1);
        make_frame(16'd24, PORT, 4, 32'd400);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1); idle(3);

        make_frame(16'd40, PORT, 2, 32'd450);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1); idle(3);
        make_frame(16'd27, PORT, 6, 32'd470);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1); idle(3);

        make_frame(16'd24, PORT, 4, 32'd500);
        exp_wr.push_back(32'd500);
        for (int unsigned i = 0; i < 12; i++) send_beat(frm[i], i == 0, 1'b0, 6'h00);
        ff_rx_data = frm[12]; ff_rx_dval = 1;
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_wr_data", wr_data, 32'd0);
        check("mid_rst_pkt_done", 32'(pkt_done), 32'd0);
        check("mid_rst_pkt_drop", 32'(pkt_drop), 32'd0);
        check("mid_rst_drop_count", 32'(drop_count), 32'd0);
        model_drops = '0;
        ff_rx_dval = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        check("rst_flush_wr_queue", 32'(exp_wr.size()), 32'd0);
        for (int unsigned i = 13; i < 15; i++) send_beat(frm[i], 1'b0, i == 14, 6'h00);
        idle(2);
        make_frame(16'd24, PORT, 4, 32'd600);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1); idle(3);

        gap_en = 1; bp_en = 1;
        for (int f = 0; f < 30; f++) begin
            make_frame(16'd8 + 16'($urandom_range(0, 27)),
                       ($urandom_range(0, 5) == 0) ? 16'($urandom) : PORT,
                       $urandom_range(0, 8), $urandom);
            k  = $urandom_range(0, 11);
            he = 1;
            e  = ($urandom_range(0, 5) == 0) ? 6'h20 : 6'h00;
            case (k)
                1: begin w = frm[1]; w[0] = ~w[0]; frm[1] = w; end
                2: begin w = frm[3]; w[8] = ~w[8]; frm[3] = w; end
                3: begin w = frm[4]; w[31:24] = 8'h46; frm[4] = w; end
                4: begin w = frm[6]; w[23:16] = 8'd6; frm[6] = w; end
                5: begin w = frm[8]; w[0] = ~w[0]; frm[8] = w; end
                6: begin w = frm[0]; w[0] = ~w[0]; frm[0] = w; end
                7: begin w = frm[10]; w[31:16] = 16'($urandom_range(0, 7)); frm[10] = w; end
                8: while (frm.size() > 1 && $urandom_range(0, 2) != 0) void'(frm.pop_back());
                9: he = 0;
                default: ;
            endcase
            push_expect(he, e);
            send_frame(he, e, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        gap_en = 0; bp_en = 0; wr_full = 0;
        make_frame(16'd24, PORT, 4, 32'd900);
        push_expect(1, 6'h00); send_frame(1, 6'h00, -1);

        for (int i = 0; i < 200 && (exp_wr.size() != 0 || exp_ev.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("ev_queue_drained", 32'(exp_ev.size()), 32'd0);
        check("final_drop_count", 32'(drop_count), 32'(model_drops));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
